// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2,
    S_WAIT  = 2'd3
  } fetch_state_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with flush, load, bubble and hold.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] INIT_PC     = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] BUBBLE_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  // Priority: flush beats load beats bubble; otherwise contents are held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst  <= BUBBLE_INST;
      pc    <= INIT_PC;
      valid <= 1'b0;
    end else if (flush) begin
      inst  <= BUBBLE_INST;
      valid <= 1'b0;
    end else if (load) begin
      inst  <= in_inst;
      pc    <= in_pc;
      valid <= 1'b1;
    end else if (bubble) begin
      inst  <= BUBBLE_INST;
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch FSM with PC, skid buffer and IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [fetch_pkg::XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [fetch_pkg::XLEN-1:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall_i,
  input  logic                      redirect_i,
  input  logic [fetch_pkg::XLEN-1:0] redirect_pc_i,
  output logic                      imem_req_o,
  output logic [fetch_pkg::XLEN-1:0] imem_addr_o,
  input  logic                      imem_rvalid_i,
  input  logic [fetch_pkg::XLEN-1:0] imem_rdata_i,
  output logic [fetch_pkg::XLEN-1:0] inst_code_o,
  output logic [fetch_pkg::XLEN-1:0] pc_o,
  output logic                      valid_o
);

  import fetch_pkg::*;

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] skid_inst;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] ifid_inst;
  logic [XLEN-1:0] ifid_pc;
  logic            req_seen;
  logic            resp;
  logic            ld;
  logic            ifid_load;

  assign target = align_word(redirect_pc_i);
  // A response only counts once the request has been visible for a full
  // cycle; this also masks responses left over from before a reset.
  assign resp   = imem_rvalid_i && imem_req_o && req_seen;
  assign ld     = !valid_o || !stall_i;

  assign ifid_load = !redirect_i &&
                     (((state == S_FETCH) && resp && ld) ||
                      ((state == S_WAIT) && !stall_i));
  assign ifid_inst = (state == S_WAIT) ? skid_inst : imem_rdata_i;
  assign ifid_pc   = (state == S_WAIT) ? skid_pc   : fetch_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_START;
      fetch_pc    <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
      skid_inst   <= NOP_INST;
      skid_pc     <= RESET_PC;
      req_seen    <= 1'b0;
    end else begin
      req_seen <= imem_req_o;
      if (redirect_i) begin
        fetch_pc <= target;
        if (((state == S_FETCH) || (state == S_DROP)) && !resp) begin
          // Outstanding request keeps its stale address until it retires.
          state <= S_DROP;
        end else begin
          state       <= S_FETCH;
          imem_req_o  <= 1'b1;
          imem_addr_o <= target;
        end
      end else begin
        case (state)
          S_START: begin
            state       <= S_FETCH;
            imem_req_o  <= 1'b1;
            imem_addr_o <= fetch_pc;
          end
          S_FETCH: begin
            if (resp) begin
              fetch_pc    <= pc_plus4(fetch_pc);
              imem_addr_o <= pc_plus4(fetch_pc);
              if (!ld) begin
                skid_inst  <= imem_rdata_i;
                skid_pc    <= fetch_pc;
                state      <= S_WAIT;
                imem_req_o <= 1'b0;
              end
            end
          end
          S_DROP: begin
            if (resp) begin
              state       <= S_FETCH;
              imem_addr_o <= fetch_pc;
            end
          end
          S_WAIT: begin
            if (!stall_i) begin
              state       <= S_FETCH;
              imem_req_o  <= 1'b1;
              imem_addr_o <= fetch_pc;
            end
          end
          default: begin
            state      <= S_START;
            imem_req_o <= 1'b0;
          end
        endcase
      end
    end
  end

  if_id_reg #(
    .INIT_PC     (RESET_PC),
    .BUBBLE_INST (NOP_INST)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_i),
    .load    (ifid_load),
    .bubble  (ld),
    .in_inst (ifid_inst),
    .in_pc   (ifid_pc),
    .inst    (inst_code_o),
    .pc      (pc_o),
    .valid   (valid_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage with a latency-configurable memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] inst_code;
  logic [31:0] pc;
  logic        valid;

  logic        tie0    = 1'b0;
  logic [31:0] tie_pc  = 32'h0;
  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic [31:0] inst2;
  logic [31:0] pc2;
  logic        valid2;
  logic        seen2;
  logic        seen_valid2;
  logic [31:0] first_pc2;
  logic [31:0] first_inst2;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb_q[$];
  logic [31:0] req_log[$];
  logic [31:0] log2[$];
  int          mem_lat;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  bit          drop_pending;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .inst_code_o   (inst_code),
    .pc_o          (pc),
    .valid_o       (valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (tie0),
    .redirect_i    (tie0),
    .redirect_pc_i (tie_pc),
    .imem_req_o    (req2),
    .imem_addr_o   (addr2),
    .imem_rvalid_i (rvalid2),
    .imem_rdata_i  (rdata2),
    .inst_code_o   (inst2),
    .pc_o          (pc2),
    .valid_o       (valid2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0093};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Redirect for one cycle; anything fetched but not yet consumed is flushed.
  task automatic do_redirect(input logic [31:0] tgt);
    redirect     = 1'b1;
    redirect_pc  = tgt;
    sb_q.delete();
    drop_pending = drop_pending || mem_busy;
    tick();
    redirect     = 1'b0;
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (req_log.size() > i) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction

  // Memory for the main instance: one response per request after mem_lat cycles.
  initial begin
    exp_t e;
    rvalid = 1'b0; rdata = 32'h0; mem_busy = 1'b0; mem_cnt = 0; drop_pending = 1'b0;
    forever begin
      @(negedge clk);
      rvalid = 1'b0;
      if (mem_busy) begin
        if (imem_req && rst_n && !drop_pending) check("addr_stable", imem_addr, mem_addr);
        mem_cnt--;
        if (mem_cnt == 0) begin
          rvalid   = 1'b1;
          rdata    = mem_word(mem_addr);
          mem_busy = 1'b0;
          if (drop_pending) drop_pending = 1'b0;
          else begin
            e.pc = mem_addr; e.inst = mem_word(mem_addr);
            sb_q.push_back(e);
          end
        end
      end else if (imem_req) begin
        mem_busy = 1'b1;
        mem_cnt  = mem_lat;
        mem_addr = imem_addr;
        req_log.push_back(imem_addr);
      end
    end
  end

  // Consumer: decode takes IF/ID at the next edge when valid, unstalled, unflushed.
  initial begin
    exp_t c;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && valid && !stall && !redirect) begin
        if (sb_q.size() == 0) check("sb_unexpected_pc", pc, 32'hFFFF_FFFF);
        else begin
          c = sb_q.pop_front();
          check("sb_pc", pc, c.pc);
          check("sb_inst", inst_code, c.inst);
        end
      end
    end
  end

  // Latency-1 memory for the wrap-around instance.
  initial begin
    rvalid2 = 1'b0; rdata2 = 32'h0; seen2 = 1'b0; seen_valid2 = 1'b0;
    first_pc2 = 32'h0; first_inst2 = 32'h0;
    forever begin
      @(negedge clk);
      rvalid2 = req2 && seen2 && !rvalid2;
      if (rvalid2) begin
        rdata2 = mem_word(addr2);
        log2.push_back(addr2);
      end
      seen2 = req2;
      if (valid2 && !seen_valid2) begin
        seen_valid2 = 1'b1; first_pc2 = pc2; first_inst2 = inst2;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int log_n;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; mem_lat = 1;
    repeat (3) tick();
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_inst",  inst_code, 32'h0000_0013);
    check("rst_pc",    pc, 32'h0);

    // Latency-1 streaming from reset
    rst_n = 1'b1;
    n = 0;
    while (!imem_req && n < 10) begin tick(); n++; end
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    tick(); tick();
    check("lat_valid", {31'd0, valid}, 32'd1);
    check("lat_pc", pc, 32'h0);
    repeat (6) tick();
    check("req_seq0", log_at(0), 32'h0);
    check("req_seq1", log_at(1), 32'h4);
    check("req_seq2", log_at(2), 32'h8);
    check("wrap_req0", (log2.size() > 0) ? log2[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("wrap_req1", (log2.size() > 1) ? log2[1] : 32'hDEAD_BEEF, 32'h0);
    check("wrap_first_pc", first_pc2, 32'hFFFF_FFFC);
    check("wrap_first_inst", first_inst2, mem_word(32'hFFFF_FFFC));

    // Stall with a response arriving into the skid register
    do_redirect(32'h4C);
    n = 0;
    while (!(valid && pc == 32'h4C) && n < 20) begin tick(); n++; end
    check("stall_pre_pc", pc, 32'h4C);
    stall = 1'b1;
    repeat (3) begin
      tick();
      check("stall_hold_inst", inst_code, mem_word(32'h4C));
      check("stall_hold_pc", pc, 32'h4C);
      check("stall_hold_valid", {31'd0, valid}, 32'd1);
    end
    check("stall_wait_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    check("stall_release_inst", inst_code, 32'h0050_0093);
    check("stall_release_pc", pc, 32'h50);

    // Redirect with a latency-3 request outstanding
    mem_lat = 3;
    n = 0;
    while (!(mem_busy && mem_cnt == 3) && n < 20) begin tick(); n++; end
    check("drop_busy", {31'd0, mem_busy}, 32'd1);
    log_n = req_log.size();
    do_redirect(32'h100);
    check("drop_valid", {31'd0, valid}, 32'd0);
    check("drop_inst", inst_code, 32'h0000_0013);
    n = 0;
    while (req_log.size() <= log_n && n < 20) begin tick(); n++; end
    check("drop_next_addr", log_at(log_n), 32'h100);
    check("drop_no_stale", {31'd0, valid}, 32'd0);
    repeat (12) tick();

    // Redirect and stall together, unaligned target
    n = 0;
    while (!valid && n < 20) begin tick(); n++; end
    stall = 1'b1;
    log_n = req_log.size();
    do_redirect(32'h102);
    check("rs_valid", {31'd0, valid}, 32'd0);
    check("rs_inst", inst_code, 32'h0000_0013);
    stall = 1'b0;
    n = 0;
    while (req_log.size() <= log_n && n < 20) begin tick(); n++; end
    check("rs_next_addr", log_at(log_n), 32'h100);
    repeat (10) tick();

    // Reset while a request is outstanding
    n = 0;
    while (!(mem_busy && mem_cnt == 3) && n < 20) begin tick(); n++; end
    rst_n = 1'b0;
    sb_q.delete();
    drop_pending = drop_pending || mem_busy;
    tick();
    check("mrst_req",   {31'd0, imem_req}, 32'd0);
    check("mrst_addr",  imem_addr, 32'h0);
    check("mrst_valid", {31'd0, valid}, 32'd0);
    check("mrst_inst",  inst_code, 32'h0000_0013);
    check("mrst_pc",    pc, 32'h0);
    tick();
    rst_n = 1'b1;
    n = 0;
    while (!valid && n < 30) begin tick(); n++; end
    check("mrst_first_pc", pc, 32'h0);
    check("mrst_first_inst", inst_code, mem_word(32'h0));
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
